// File: rtl/sc_stream_decoder.sv
// Stochastic bitstream decoder: counts ones over a window of 2**LOG_LEN
// accepted bits and reports the raw count plus a unipolar/bipolar value.
module sc_stream_decoder #(
    parameter int LOG_LEN = 8,
    parameter int SKIP    = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               bipolar,
    input  logic               en,
    input  logic               x,
    output logic               busy,
    output logic               done,
    output logic [LOG_LEN:0]   ones,
    output logic [LOG_LEN+1:0] value
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SKIP,
        S_COUNT,
        S_DONE
    } state_t;

    localparam logic [LOG_LEN-1:0] SKIP_LAST =
        (SKIP > 0) ? LOG_LEN'(SKIP - 1) : '0;
    localparam logic [LOG_LEN-1:0] BIT_LAST  = '1;
    localparam logic [LOG_LEN+1:0] OFFSET    = {2'b01, {LOG_LEN{1'b0}}};
    localparam state_t             FIRST     = (SKIP > 0) ? S_SKIP : S_COUNT;

    state_t             state;
    logic               mode;
    logic [LOG_LEN-1:0] skip_cnt;
    logic [LOG_LEN-1:0] bit_cnt;
    logic [LOG_LEN:0]   ones_cnt;
    logic [LOG_LEN:0]   ones_nxt;
    logic [LOG_LEN+1:0] result;

    // Result is formed from the count including the bit being accepted now.
    always_comb begin
        ones_nxt = ones_cnt + {{LOG_LEN{1'b0}}, x};
        result   = mode ? ({ones_nxt, 1'b0} - OFFSET) : {1'b0, ones_nxt};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            mode     <= 1'b0;
            skip_cnt <= '0;
            bit_cnt  <= '0;
            ones_cnt <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ones     <= '0;
            value    <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state    <= FIRST;
                        mode     <= bipolar;
                        skip_cnt <= '0;
                        bit_cnt  <= '0;
                        ones_cnt <= '0;
                        busy     <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_SKIP: begin
                    if (en) begin
                        skip_cnt <= skip_cnt + 1'b1;
                        if (skip_cnt == SKIP_LAST) begin
                            state <= S_COUNT;
                        end
                    end
                end
                S_COUNT: begin
                    if (en) begin
                        ones_cnt <= ones_nxt;
                        bit_cnt  <= bit_cnt + 1'b1;
                        if (bit_cnt == BIT_LAST) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            ones  <= ones_nxt;
                            value <= result;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sc_stream_decoder.sv
// Directed bench for sc_stream_decoder at LOG_LEN=4 (SKIP=0 and SKIP=2).
module tb_sc_stream_decoder;

    logic       clk;
    logic       reset;
    logic       start;
    logic       bipolar;
    logic       en;
    logic       x;
    logic       busy;
    logic       done;
    logic [4:0] ones;
    logic [5:0] value;
    logic       s_busy;
    logic       s_done;
    logic [4:0] s_ones;
    logic [5:0] s_value;

    int total = 0;
    int bad   = 0;

    sc_stream_decoder #(.LOG_LEN(4), .SKIP(0)) dut (
        .clk(clk), .reset(reset), .start(start), .bipolar(bipolar),
        .en(en), .x(x), .busy(busy), .done(done), .ones(ones), .value(value)
    );

    sc_stream_decoder #(.LOG_LEN(4), .SKIP(2)) dut_s (
        .clk(clk), .reset(reset), .start(start), .bipolar(bipolar),
        .en(en), .x(x), .busy(s_busy), .done(s_done), .ones(s_ones),
        .value(s_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs; returns at the following falling edge.
    task automatic step(input logic s, input logic b, input logic e,
                        input logic xx);
        start   = s;
        bipolar = b;
        en      = e;
        x       = xx;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        reset = 1'b1;
        step(0, 0, 0, 0);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        total++;
        if ({busy, done, ones, value} !== 13'd0) begin
            bad++;
            $display("FAIL reset_outputs got busy=%b done=%b ones=%0d value=%0d want all 0",
                     busy, done, ones, value);
        end
        total++;
        if ({s_busy, s_done, s_ones, s_value} !== 13'd0) begin
            bad++;
            $display("FAIL reset_outputs_skip got busy=%b done=%b ones=%0d value=%0d want all 0",
                     s_busy, s_done, s_ones, s_value);
        end
        reset = 1'b1;
        step(0, 0, 1, 1);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL idle_ignores_en got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_unipolar();
        step(1, 0, 0, 0);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL uni_busy_after_start got %b want 1", busy);
        end
        for (int i = 0; i < 15; i++) begin
            step(0, 0, 1, 1);
            total++;
            if (done !== 1'b0 || busy !== 1'b1) begin
                bad++;
                $display("FAIL uni_early beat=%0d got done=%b busy=%b want 0 1",
                         i + 1, done, busy);
            end
        end
        step(0, 0, 1, 1);
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || ones !== 5'd16 || value !== 6'd16) begin
            bad++;
            $display("FAIL uni_result got done=%b busy=%b ones=%0d value=%0d want 1 0 16 16",
                     done, busy, ones, value);
        end
        step(0, 0, 0, 0);
        total++;
        if (done !== 1'b0 || ones !== 5'd16 || value !== 6'd16) begin
            bad++;
            $display("FAIL uni_hold got done=%b ones=%0d value=%0d want 0 16 16",
                     done, ones, value);
        end
    endtask

    task automatic test_bipolar();
        // bipolar dropped after start must not change the captured mode
        step(1, 1, 0, 0);
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 1, (i % 2) == 0);
            if (i < 15) begin
                total++;
                if (done !== 1'b0) begin
                    bad++;
                    $display("FAIL bip_alt_early beat=%0d got done=%b want 0", i + 1, done);
                end
            end
        end
        total++;
        if (done !== 1'b1 || ones !== 5'd8 || value !== 6'd0) begin
            bad++;
            $display("FAIL bip_alt got done=%b ones=%0d value=%0d want 1 8 0",
                     done, ones, value);
        end
        step(0, 0, 0, 0);
        step(1, 1, 0, 0);
        for (int i = 0; i < 16; i++) step(0, 1, 1, 0);
        total++;
        if (done !== 1'b1 || ones !== 5'd0 || value !== 6'b110000) begin
            bad++;
            $display("FAIL bip_zero got done=%b ones=%0d value=%b want 1 0 110000",
                     done, ones, value);
        end
        step(0, 0, 0, 0);
    endtask

    task automatic test_gaps();
        logic xb;
        step(1, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            if (i % 3 == 1) begin
                step(0, 0, 0, 1);
                total++;
                if (busy !== 1'b1 || done !== 1'b0) begin
                    bad++;
                    $display("FAIL gap_idle beat=%0d got busy=%b done=%b want 1 0",
                             i, busy, done);
                end
            end
            xb = (i == 0 || i == 3 || i == 7 || i == 8 || i == 15);
            step(0, 0, 1, xb);
            if (i < 15) begin
                total++;
                if (busy !== 1'b1 || done !== 1'b0) begin
                    bad++;
                    $display("FAIL gap_beat beat=%0d got busy=%b done=%b want 1 0",
                             i + 1, busy, done);
                end
            end
        end
        total++;
        if (done !== 1'b1 || ones !== 5'd5 || value !== 6'd5) begin
            bad++;
            $display("FAIL gap_result got done=%b ones=%0d value=%0d want 1 5 5",
                     done, ones, value);
        end
        step(0, 0, 0, 0);
    endtask

    task automatic test_skip();
        do_reset();
        step(1, 0, 0, 0);
        for (int i = 0; i < 18; i++) begin
            step(0, 0, 1, i < 2);
            if (i == 15) begin
                total++;
                if (done !== 1'b1 || ones !== 5'd2) begin
                    bad++;
                    $display("FAIL noskip_ref got done=%b ones=%0d want 1 2", done, ones);
                end
            end
            if (i < 17) begin
                total++;
                if (s_done !== 1'b0 || s_busy !== 1'b1) begin
                    bad++;
                    $display("FAIL skip_early beat=%0d got done=%b busy=%b want 0 1",
                             i + 1, s_done, s_busy);
                end
            end
        end
        total++;
        if (s_done !== 1'b1 || s_busy !== 1'b0 || s_ones !== 5'd0 || s_value !== 6'd0) begin
            bad++;
            $display("FAIL skip_result got done=%b busy=%b ones=%0d value=%0d want 1 0 0 0",
                     s_done, s_busy, s_ones, s_value);
        end
        step(0, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        step(1, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            step(i == 8, 1, 1, i <= 8);
            if (i < 15) begin
                total++;
                if (done !== 1'b0 || busy !== 1'b1) begin
                    bad++;
                    $display("FAIL restart_early beat=%0d got done=%b busy=%b want 0 1",
                             i + 1, done, busy);
                end
            end
        end
        total++;
        if (done !== 1'b1 || ones !== 5'd9 || value !== 6'd9) begin
            bad++;
            $display("FAIL restart_ignored got done=%b ones=%0d value=%0d want 1 9 9",
                     done, ones, value);
        end
        step(1, 1, 1, 1);
        total++;
        if (busy !== 1'b1 || done !== 1'b0 || ones !== 5'd9) begin
            bad++;
            $display("FAIL b2b_start got busy=%b done=%b ones=%0d want 1 0 9",
                     busy, done, ones);
        end
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 1, 1);
            if (i < 15) begin
                total++;
                if (done !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b_early beat=%0d got done=%b want 0", i + 1, done);
                end
            end
        end
        total++;
        if (done !== 1'b1 || ones !== 5'd16 || value !== 6'd16) begin
            bad++;
            $display("FAIL b2b_result got done=%b ones=%0d value=%0d want 1 16 16",
                     done, ones, value);
        end
        step(0, 0, 0, 0);
    endtask

    task automatic test_reset_mid();
        step(1, 1, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 1, 1, 1);
        #2 reset = 1'b0;
        #1;
        total++;
        if ({busy, done, ones, value} !== 13'd0) begin
            bad++;
            $display("FAIL async_reset got busy=%b done=%b ones=%0d value=%0d want all 0",
                     busy, done, ones, value);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 1, 1);
            total++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL post_reset_idle cyc=%0d got done=%b busy=%b want 0 0",
                         i, done, busy);
            end
        end
        step(1, 1, 0, 0);
        for (int i = 0; i < 16; i++) step(0, 0, 1, i < 12);
        total++;
        if (done !== 1'b1 || ones !== 5'd12 || value !== 6'd8) begin
            bad++;
            $display("FAIL post_reset_window got done=%b ones=%0d value=%0d want 1 12 8",
                     done, ones, value);
        end
        step(0, 0, 0, 0);
    endtask

    initial begin
        reset   = 1'b0;
        start   = 1'b0;
        bipolar = 1'b0;
        en      = 1'b0;
        x       = 1'b0;
        test_reset();
        test_unipolar();
        test_bipolar();
        test_gaps();
        test_skip();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
